// File: rtl/bus_trace_if.sv
// Snooped-bus and trace-output bundle for bus_trace.
interface bus_trace_if;
  logic        enable;
  logic        baud_tick;
  logic [15:0] address;
  logic [7:0]  outdata;
  logic        store;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [6:0]  count;

  modport master (
    output enable, baud_tick, address, outdata, store,
    input  tx, busy, overflow, count
  );

  modport slave (
    input  enable, baud_tick, address, outdata, store,
    output tx, busy, overflow, count
  );
endinterface

// File: rtl/bus_trace.sv
// Bus store tracer: captures in-window stores into a FIFO and streams each
// record as three 8N1 UART bytes (addr hi, addr lo, data).
module bus_trace #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] ADDR_LO    = 16'hff00,
  parameter logic [15:0] ADDR_HI    = 16'hffff
) (
  input  logic        clock,
  input  logic        reset,
  bus_trace_if.slave  bus
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          store_q, store_in_rst;
  logic          store_evt, addr_hit;
  logic          pend_valid;
  logic [23:0]   pend_rec;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [6:0]    count;
  logic          overflow;
  logic          full, push, pop, push_ok;
  logic [1:0]    byte_idx, byte_idx_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [23:0]   rec;
  logic [7:0]    cur_byte;
  logic          serial_bit, active;

  // The edge register is cleared in reset; store_in_rst remembers a store
  // level already present during reset so it is not seen as a fresh edge.
  assign store_evt = bus.store & ~store_q & ~store_in_rst;
  assign addr_hit  = ({1'b0, bus.address} >= {1'b0, ADDR_LO}) &&
                     ({1'b0, bus.address} <= {1'b0, ADDR_HI});

  assign full    = (count == 7'(FIFO_DEPTH));
  assign pop     = (state == IDLE) && bus.baud_tick && (count != '0);
  assign push    = pend_valid;
  assign push_ok = push && (!full || pop);

  // Store edge detection and one-cycle capture stage
  always_ff @(posedge clock) begin
    if (reset) begin
      store_q      <= 1'b0;
      store_in_rst <= bus.store;
      pend_valid   <= 1'b0;
      pend_rec     <= '0;
    end else begin
      store_q      <= bus.store;
      store_in_rst <= 1'b0;
      pend_valid   <= store_evt & bus.enable & addr_hit;
      if (store_evt) pend_rec <= {bus.address, bus.outdata};
    end
  end

  // FIFO storage write
  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem[wr_ptr] <= pend_rec;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && full && !pop) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

  // Transmitter state register and popped record
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      bit_idx  <= '0;
      rec      <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      bit_idx  <= bit_idx_nxt;
      if (pop) rec <= mem[rd_ptr];
    end
  end

  // Transmitter next state: advances only on baud_tick
  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    bit_idx_nxt  = bit_idx;
    if (bus.baud_tick) begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state_nxt    = START;
            byte_idx_nxt = '0;
            bit_idx_nxt  = '0;
          end
        end
        START: begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
        DATA: begin
          if (bit_idx == 3'd7) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
        STOP: begin
          if (byte_idx < 2'd2) begin
            state_nxt    = START;
            byte_idx_nxt = byte_idx + 2'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Transmitter outputs: serial line and busy
  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = rec[23:16];
      2'd1:    cur_byte = rec[15:8];
      default: cur_byte = rec[7:0];
    endcase
    serial_bit = 1'b1;
    case (state)
      START:   serial_bit = 1'b0;
      DATA:    serial_bit = cur_byte[bit_idx];
      default: serial_bit = 1'b1;
    endcase
    active = (count != '0) || (state != IDLE);
    if (reset) begin
      serial_bit = 1'b1;
      active     = 1'b0;
    end
  end

  assign bus.tx       = serial_bit;
  assign bus.busy     = active;
  assign bus.overflow = overflow;
  assign bus.count    = count;
endmodule

// File: tb/tb_bus_trace.sv
// Self-checking bench for bus_trace: a UART receiver model decodes tx and a
// record queue built from the capture rules predicts what must appear.
module tb_bus_trace;
  localparam int unsigned DEPTH  = 16;
  localparam logic [15:0] LO     = 16'hff00;
  localparam logic [15:0] HI     = 16'hfff0;
  localparam int          TICK_P = 3;
  localparam int          BUDGET = 6000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  bus_trace_if bus();

  bus_trace #(.FIFO_DEPTH(DEPTH), .ADDR_LO(LO), .ADDR_HI(HI)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  bit          tick_en = 1'b0;
  bit          tick_force = 1'b0;
  int          tick_cnt = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  rx_q[$];
  int          rx_phase = 0;
  logic        cur_bit = 1'b1;
  logic [7:0]  rx_sh = '0;
  logic        m_tick, m_rst;
  bit          m_ovf = 1'b0;

  // Baud tick generator (periodic, or a single forced pulse)
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clock); #1;
      if (tick_en) begin
        tick_cnt++;
        bus.baud_tick = (tick_cnt % TICK_P == 0);
      end else begin
        tick_cnt = 0;
        bus.baud_tick = tick_force;
      end
    end
  end

  // UART receiver: a new bit interval starts at every tick edge
  initial begin
    forever begin
      @(posedge clock);
      m_tick = bus.baud_tick;
      m_rst  = reset;
      #1;
      if (m_rst) begin
        rx_phase = 0;
        cur_bit  = 1'b1;
      end else if (m_tick) begin
        cur_bit = bus.tx;
        if (rx_phase == 0) begin
          if (cur_bit === 1'b0) rx_phase = 1;
        end else if (rx_phase <= 8) begin
          rx_sh = {cur_bit, rx_sh[7:1]};
          rx_phase++;
        end else begin
          tests++;
          if (cur_bit !== 1'b1) begin
            fails++;
            $display("FAIL stop_bit: tx=%b required 1", cur_bit);
          end
          rx_q.push_back(rx_sh);
          rx_phase = 0;
        end
      end else begin
        tests++;
        if (bus.tx !== cur_bit) begin
          fails++;
          $display("FAIL tx_stable: tx=%b required %b (changed without tick)", bus.tx, cur_bit);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void model_store(input logic [15:0] a, input logic [7:0] d, input bit pop_now);
    if (bus.enable === 1'b1 && a >= LO && a <= HI) begin
      if (!tick_en && !pop_now && exp_q.size() >= int'(DEPTH)) m_ovf = 1'b1;
      else exp_q.push_back({a, d});
    end
  endfunction

  task automatic do_store(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clock);
    bus.address = a;
    bus.outdata = d;
    bus.store   = 1'b1;
    model_store(a, d, 1'b0);
    for (int i = 1; i < hold; i++) begin
      @(negedge clock);
      bus.address = 16'($urandom);
      bus.outdata = 8'($urandom);
    end
    @(negedge clock);
    bus.store = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (3) @(negedge clock);
    while ((bus.busy !== 1'b0 || rx_phase != 0) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (n >= BUDGET) begin
      fails++;
      $display("FAIL %s_drain_timeout: busy=%b required 0", name, bus.busy);
    end
  endtask

  task automatic check_drain(input string name);
    wait_idle(name);
    while (exp_q.size() > 0) begin
      logic [23:0] e;
      logic [7:0]  b0, b1, b2;
      e = exp_q.pop_front();
      tests++;
      if (rx_q.size() < 3) begin
        fails++;
        $display("FAIL %s_missing: record absent, required %h", name, e);
      end else begin
        b0 = rx_q.pop_front();
        b1 = rx_q.pop_front();
        b2 = rx_q.pop_front();
        if ({b0, b1, b2} !== e) begin
          fails++;
          $display("FAIL %s_record: got %h required %h", name, {b0, b1, b2}, e);
        end
      end
    end
    tests++;
    if (rx_q.size() != 0) begin
      fails++;
      $display("FAIL %s_extra: %0d stray bytes, required 0", name, rx_q.size());
      rx_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.address = 16'hff10;
    bus.outdata = 8'h99;
    bus.store = 1'b1;
    repeat (3) @(negedge clock);
    tests++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b required 1", bus.tx); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
    tests++; if (bus.count !== 7'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", bus.count); end
    reset = 1'b0;
    repeat (4) @(negedge clock);
    bus.store = 1'b0;
    repeat (4) @(negedge clock);
    tests++; if (bus.count !== 7'd0) begin fails++; $display("FAIL store_held_through_reset: count=%0d required 0", bus.count); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL store_held_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_single();
    tick_en = 1'b0;
    do_store(16'hff01, 8'h41, 1);
    tests++; if (bus.count !== 7'd0) begin fails++; $display("FAIL single_count_early: got %0d required 0", bus.count); end
    @(negedge clock);
    tests++; if (bus.count !== 7'd1) begin fails++; $display("FAIL single_count: got %0d required 1", bus.count); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b required 1", bus.busy); end
    tick_en = 1'b1;
    check_drain("single");
    tick_en = 1'b0;
  endtask

  task automatic test_filter_edge();
    tick_en = 1'b0;
    do_store(16'hc000, 8'h55, 1);
    do_store(16'hff05, 8'h07, 5);
    repeat (3) @(negedge clock);
    tests++; if (bus.count !== 7'(exp_q.size())) begin fails++; $display("FAIL filter_count: got %0d required %0d", bus.count, exp_q.size()); end
    tick_en = 1'b1;
    check_drain("filter_edge");
    tick_en = 1'b0;
  endtask

  task automatic test_overflow();
    tick_en = 1'b0;
    for (int i = 0; i < 17; i++) do_store(16'hff80 + 16'(i), 8'($urandom), 1);
    repeat (2) @(negedge clock);
    tests++; if (bus.count !== 7'(exp_q.size())) begin fails++; $display("FAIL ovf_count: got %0d required %0d", bus.count, exp_q.size()); end
    tests++; if (bus.overflow !== m_ovf) begin fails++; $display("FAIL ovf_flag: got %b required %b", bus.overflow, m_ovf); end
    tick_en = 1'b1;
    check_drain("overflow");
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b required 1", bus.overflow); end
    tick_en = 1'b0;
    apply_reset();
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %b required 0", bus.overflow); end
  endtask

  task automatic test_full_pop();
    logic [7:0] d;
    tick_en = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) do_store(16'hff20 + 16'(i), 8'($urandom), 1);
    repeat (2) @(negedge clock);
    tests++; if (bus.count !== 7'(DEPTH)) begin fails++; $display("FAIL full_count: got %0d required %0d", bus.count, DEPTH); end
    d = 8'($urandom);
    @(negedge clock);
    bus.address = 16'hff40;
    bus.outdata = d;
    bus.store = 1'b1;
    model_store(16'hff40, d, 1'b1);
    @(negedge clock);
    bus.store = 1'b0;
    tick_force = 1'b1;
    @(negedge clock);
    tick_force = 1'b0;
    tests++; if (bus.count !== 7'(DEPTH)) begin fails++; $display("FAIL fullpop_count: got %0d required %0d", bus.count, DEPTH); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL fullpop_overflow: got %b required 0", bus.overflow); end
    tick_en = 1'b1;
    check_drain("full_pop");
    tick_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    tick_en = 1'b1;
    do_store(16'hff33, 8'ha5, 1);
    while (!(rx_q.size() == 1 && rx_phase == 5) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    tests++; if (n >= BUDGET) begin fails++; $display("FAIL midframe_wait: byte1 bit3 not reached, required within %0d cycles", BUDGET); end
    reset = 1'b1;
    @(negedge clock);
    tests++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL midreset_tx: got %b required 1", bus.tx); end
    tests++; if (bus.count !== 7'd0) begin fails++; $display("FAIL midreset_count: got %0d required 0", bus.count); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b required 0", bus.busy); end
    reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
    m_ovf = 1'b0;
    do_store(16'hff34, 8'h5a, 1);
    check_drain("after_reset");
    tick_en = 1'b0;
  endtask

  task automatic test_enable();
    int n = 0;
    tick_en = 1'b0;
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) do_store(16'hff50 + 16'(i), 8'($urandom), 1);
    repeat (3) @(negedge clock);
    tests++; if (bus.count !== 7'(exp_q.size())) begin fails++; $display("FAIL enable_gate_count: got %0d required %0d", bus.count, exp_q.size()); end
    bus.enable = 1'b1;
    tick_en = 1'b1;
    do_store(16'hff60, 8'hc3, 1);
    while (!(rx_q.size() == 1 && rx_phase == 3) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    tests++; if (n >= BUDGET) begin fails++; $display("FAIL enable_wait: frame not started, required within %0d cycles", BUDGET); end
    bus.enable = 1'b0;
    do_store(16'hff61, 8'h3c, 1);
    check_drain("enable_midframe");
    bus.enable = 1'b1;
    tick_en = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] a;
    tick_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(12, 4));
      for (int k = 0; k < n; k++) begin
        bus.enable = ($urandom_range(7, 0) != 0);
        case ($urandom_range(5, 0))
          0:       a = LO;
          1:       a = HI;
          2:       a = LO - 16'd1;
          3:       a = HI + 16'd1;
          4:       a = LO + 16'($urandom_range(240, 0));
          default: a = 16'($urandom);
        endcase
        do_store(a, 8'($urandom), int'($urandom_range(3, 1)));
        repeat ($urandom_range(2, 0)) @(negedge clock);
      end
      bus.enable = 1'b1;
      check_drain("random");
    end
    tick_en = 1'b0;
  endtask

  initial begin
    bus.enable  = 1'b1;
    bus.address = '0;
    bus.outdata = '0;
    bus.store   = 1'b0;
    test_reset();
    test_single();
    test_filter_edge();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_trace.md
BUS_TRACE -- requirements
Module: bus_trace

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning number of queued trace records (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_LO, default 16'hff00, meaning the lowest traced store address (inclusive).
REQ-003 SHALL have parameter ADDR_HI, default 16'hffff, meaning the highest traced store address (inclusive).
REQ-004 SHALL have port clock  in  1  system clock (clockgb domain); all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port enable  in  1  capture enable; when low, no new records are captured.
REQ-007 SHALL have port baud_tick  in  1  one-cycle strobe, once per UART bit period.
REQ-008 SHALL have port address  in  16  snooped bus address.
REQ-009 SHALL have port outdata  in  8  snooped bus write data.
REQ-010 SHALL have port store  in  1  snooped bus store strobe (level, may be held multiple cycles).
REQ-011 SHALL have port tx  out  1  UART 8N1 serial output, idle high.
REQ-012 SHALL have port busy  out  1  high while FIFO non-empty or a record is being transmitted.
REQ-013 SHALL have port overflow  out  1  sticky flag: a record was dropped.
REQ-014 SHALL have port count  out  7  number of records currently in the FIFO.

Function
REQ-015 SHALL detect a store event when store is 1 this cycle and 0 the previous cycle (rising edge); a held store produces exactly one event.
REQ-016 SHALL capture a record {address, outdata} of 24 bits on a store event only if enable=1 and ADDR_LO <= address <= ADDR_HI (unsigned).
REQ-017 SHALL sample address and outdata in the same cycle as the store rising edge.
REQ-018 SHALL push a captured record into the FIFO in the cycle after the event; count increments in the cycle after the push.
REQ-019 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; count stays unchanged.
REQ-020 SHALL drop the record and set overflow when a push occurs with the FIFO full and no simultaneous pop; FIFO contents are unaffected.
REQ-021 SHALL keep overflow set until reset.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH; records leave in push order.
REQ-023 SHALL implement the transmitter FSM with states IDLE, START, DATA, STOP and a byte index 0..2.
REQ-024 SHALL, in IDLE on baud_tick with count>0, pop one record, set byte index 0, and enter START.
REQ-025 SHALL send each record as three bytes in order: address[15:8], address[7:0], data.
REQ-026 SHALL drive tx=0 in START, the current data bit (LSB first) in DATA, and tx=1 in STOP and IDLE.
REQ-027 SHALL advance START->DATA(bit 0)->...->DATA(bit 7)->STOP, one step per baud_tick only; no state changes without baud_tick.
REQ-028 SHALL, in STOP on baud_tick, enter START with the next byte if byte index<2, else enter IDLE.
REQ-029 SHALL hold every serial bit for exactly one baud_tick interval; one record occupies exactly 30 baud_tick intervals.
REQ-030 SHALL continue transmitting a popped record when enable goes low; enable gates capture only.
REQ-031 SHALL ignore baud_tick pulses while IDLE with an empty FIFO.

Reset
REQ-032 SHALL, while reset=1, force tx=1, busy=0, overflow=0, count=0, FSM=IDLE, byte index=0, both pointers=0, and the store-edge register=0.
REQ-033 SHALL abort any in-progress frame on reset; tx returns to 1 in the cycle after reset is sampled high.
REQ-034 SHALL not detect a store event in the first cycle after reset if store was already high during reset.

Verification
REQ-035 Single store: store 0xff01<-0x41, 1 cycle -> count=1 two cycles later; tx emits bytes 0xff, 0x01, 0x41 with 8N1 framing over 30 ticks; busy falls after final stop bit.
REQ-036 Filter/edge: store 0xc000<-0x55, then 0xff05<-0x07 held 5 cycles -> exactly one record {0xff05,0x07}; 0xc000 absent.
REQ-037 Overflow: baud_tick held 0, 17 distinct stores to 0xff80..0xff90 -> count=16, overflow=1; ticks resumed -> first 16 records sent in order, 17th absent.
REQ-038 Full+pop: FIFO full, store coincident with IDLE pop -> record accepted, count stays 16, overflow stays 0.
REQ-039 Reset mid-frame: reset asserted during DATA bit 3 of byte 1 -> tx=1, count=0, busy=0 next cycle; new store after release transmits cleanly from START.
REQ-040 Enable gating: enable=0 during 3 stores -> count=0; enable dropped mid-frame -> current record completes all 30 bits.
